// File: rtl/ram_slot_allocator_pkg.sv
// ram_slot_allocator_pkg
// Shared memory-system definitions: RAM geometry, the slot-index and
// occupancy-bitmap types, and a one-hot helper used when updating the
// occupancy bitmap.
package ram_slot_allocator_pkg;

    localparam int SIZE_RAM     = 32;
    localparam int SIZE_RAM_LOG = 5;

    typedef logic [SIZE_RAM_LOG-1:0] slot_idx_t;
    typedef logic [SIZE_RAM-1:0]     ram_bitmap_t;
    // One extra bit so that a completely full RAM (SIZE_RAM) is representable.
    typedef logic [SIZE_RAM_LOG:0]   slot_count_t;

    // Bitmap with only bit idx set.
    function automatic ram_bitmap_t slot_onehot(input slot_idx_t idx);
        ram_bitmap_t v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/ram_slot_allocator_first_free.sv
// ram_first_free
// Purely combinational free-slot search over an occupancy bitmap.
// Ports:
//   bitmap   in   occupancy bitmap, bit i set = slot i in use
//   idx      out  lowest i with bitmap[i]==0 (0 when nothing is free)
//   any_free out  at least one bit of bitmap is 0
module ram_first_free
    import ram_slot_allocator_pkg::*;
(
    input  ram_bitmap_t bitmap,
    output slot_idx_t   idx,
    output logic        any_free
);

    // Scan from the top down so the last assignment is the lowest free slot.
    always_comb begin
        idx = '0;
        for (int i = SIZE_RAM - 1; i >= 0; i--) begin
            if (!bitmap[i]) begin
                idx = SIZE_RAM_LOG'(i);
            end
        end
    end

    assign any_free = ~&bitmap;

endmodule

// File: rtl/ram_slot_allocator.sv
// ram_slot_allocator
// Owns the occupancy bitmap of the RAM, grants the lowest free slot to one
// requester per cycle under round-robin arbitration and retires slots on the
// free port. All outputs are registered.
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   alloc_req  per-requester level request, held until granted
//   alloc_gnt  one-hot grant pulse, one cycle
//   alloc_idx  slot index accompanying the grant
//   free_vld   release request (one slot per cycle)
//   free_idx   slot to release
//   free_err   pulse: previous cycle's free hit an unoccupied or invalid slot
//   ram_valid  occupancy bitmap
//   count      number of occupied slots
//   full       count == SIZE_RAM
//   empty      count == 0
//
// Handshake: a requester raises alloc_req[i] and holds it; the cycle in which
// alloc_gnt[i] is high completes the transfer and alloc_idx is valid only in
// that cycle. The requester drops or re-asserts its request afterwards; a
// still-held request is masked for the grant cycle, so one request is never
// granted twice. free_vld has no back-pressure: every free is consumed in the
// cycle it is presented.
module ram_slot_allocator
    import ram_slot_allocator_pkg::*;
#(
    parameter int NUM_REQ = 2
)
(
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] alloc_req,
    output logic [NUM_REQ-1:0] alloc_gnt,
    output slot_idx_t          alloc_idx,
    input  logic               free_vld,
    input  slot_idx_t          free_idx,
    output logic               free_err,
    output ram_bitmap_t        ram_valid,
    output slot_count_t        count,
    output logic               full,
    output logic               empty
);

    localparam int RR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [RR_W-1:0]    rr_ptr;      // last winner
    logic [NUM_REQ-1:0] eligible;
    logic               win_found;
    logic [RR_W-1:0]    win_sel;
    logic               grant;

    slot_idx_t          search_idx;
    logic               any_free;

    logic               free_in_range;
    logic               free_hit;

    ram_bitmap_t        ram_valid_n;
    slot_count_t        count_n;

    // Search runs on the registered bitmap, so a slot freed this cycle is
    // not visible to the allocator until the next one.
    ram_first_free u_first_free (
        .bitmap   (ram_valid),
        .idx      (search_idx),
        .any_free (any_free)
    );

    assign eligible = alloc_req & ~alloc_gnt;

    // Round-robin: first eligible requester starting after rr_ptr.
    always_comb begin : arb_search
        int cand;
        win_found = 1'b0;
        win_sel   = rr_ptr;
        cand      = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = (int'(rr_ptr) + k) % NUM_REQ;
            if (!win_found && eligible[cand]) begin
                win_found = 1'b1;
                win_sel   = RR_W'(cand);
            end
        end
    end

    // full and any_free agree by construction; both are kept so a corrupted
    // bitmap can never hand out an occupied slot.
    assign grant = win_found && !full && any_free;

    // Zero-extended compare keeps this meaningful for non power-of-two sizes.
    assign free_in_range = ({1'b0, free_idx} < slot_count_t'(SIZE_RAM));
    assign free_hit      = free_vld && free_in_range && ram_valid[free_idx];

    // The granted slot has bit 0 and a hit free has bit 1, so set and clear
    // never target the same slot.
    always_comb begin
        ram_valid_n = ram_valid;
        if (grant) begin
            ram_valid_n = ram_valid_n | slot_onehot(search_idx);
        end
        if (free_hit) begin
            ram_valid_n = ram_valid_n & ~slot_onehot(free_idx);
        end
    end

    assign count_n = count + slot_count_t'(grant) - slot_count_t'(free_hit);

    always_ff @(posedge clk) begin
        if (rst) begin
            alloc_gnt <= '0;
            alloc_idx <= '0;
            free_err  <= 1'b0;
            ram_valid <= '0;
            count     <= '0;
            full      <= 1'b0;
            empty     <= 1'b1;
            rr_ptr    <= RR_W'(NUM_REQ - 1);
        end else begin
            free_err  <= free_vld && !free_hit;
            ram_valid <= ram_valid_n;
            count     <= count_n;
            full      <= (count_n == slot_count_t'(SIZE_RAM));
            empty     <= (count_n == '0);
            if (grant) begin
                alloc_gnt <= NUM_REQ'(1) << win_sel;
                alloc_idx <= search_idx;
                rr_ptr    <= win_sel;
            end else begin
                alloc_gnt <= '0;
            end
        end
    end

endmodule
